mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_responder_if.sv | 32 +++
 rtl/mem_responder_store.sv | 31 +++
 rtl/mem_responder.sv | 132 +++++++++++++
 tb/tb_mem_responder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-memory request path: FSM states and default geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDATA  = 2'd1,
    RLAT   = 2'd2,
    RBURST = 2'd3
  } state_t;

  localparam int DEF_MEM_ADDR_BITS = 28;
  localparam int DEF_DATA_BITS     = 128;
  localparam int DEF_MASK_BITS     = DEF_DATA_BITS / 8;
  localparam int DEF_DEPTH_BITS    = 10;
  localparam int DEF_BURST_BEATS   = 4;
  localparam int DEF_READ_LATENCY  = 1;

endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bundle; the cache drives the master side, memory the slave side.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS
) ();

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_req_rw;
  logic                     mem_req_data_valid;
  logic                     mem_req_data_ready;
  logic [DATA_BITS-1:0]     mem_req_data_bits;
  logic [DATA_BITS/8-1:0]   mem_req_data_mask;
  logic                     mem_resp_valid;
  logic [DATA_BITS-1:0]     mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_rw,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_rw,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/mem_responder_store.sv
// Byte-lane 1R1W storage: synchronous read (output holds when re=0), byte-masked write, no reset.
module mem_responder_store #(
  parameter int DATA_BITS  = 128,
  parameter int DEPTH_BITS = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_BITS-1:0]  waddr,
  input  logic [DATA_BITS-1:0]   wdata,
  input  logic [DATA_BITS/8-1:0] wmask,
  input  logic                   re,
  input  logic [DEPTH_BITS-1:0]  raddr,
  output logic [DATA_BITS-1:0]   rdata
);

  localparam int LANES = DATA_BITS / 8;
  localparam int WORDS = 1 << DEPTH_BITS;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] mem_q [WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we && wmask[g]) mem_q[waddr] <= wdata[8*g +: 8];
      if (re)             rd_q <= mem_q[raddr];
    end

    assign rdata[8*g +: 8] = rd_q;
  end

endmodule

// File: rtl/mem_responder.sv
// Backing-memory responder: masked line writes, fixed-latency wrapped read bursts (critical word first).
// Readies depend on state only; the response burst cannot be stalled.
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int DEPTH_BITS    = DEF_DEPTH_BITS,
  parameter int BURST_BEATS   = DEF_BURST_BEATS,
  parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave mem
);

  localparam int LB = $clog2(BURST_BEATS);
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LB-1:0] BEAT_LAST    = LB'(BURST_BEATS - 1);
  localparam logic [LW-1:0] LAT_LAST     = LW'(READ_LATENCY - 1);
  localparam bit            DIRECT_BURST = (READ_LATENCY == 1);

  state_t                state;
  logic [DEPTH_BITS-1:0] base;
  logic [LB-1:0]         beat_cnt;
  logic [LW-1:0]         lat_cnt;
  logic                  resp_valid;
  logic                  data_seen;

  logic [DEPTH_BITS-1:0] idx_in;
  logic                  accept;
  logic                  we;
  logic [DEPTH_BITS-1:0] waddr;
  logic                  re;
  logic [DEPTH_BITS-1:0] rd_base;
  logic [LB-1:0]         rd_off;
  logic [DEPTH_BITS-1:0] raddr;
  logic [DATA_BITS-1:0]  rd_data;
  logic                  unused_addr;

  assign idx_in      = mem.mem_req_addr[DEPTH_BITS-1:0];
  assign unused_addr = ^mem.mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS];
  assign accept      = (state == IDLE) && mem.mem_req_valid;

  assign we = ~reset && mem.mem_req_data_valid &&
              ((accept && mem.mem_req_rw) || (state == WDATA));
  assign waddr = (state == WDATA) ? base : idx_in;

  // Each store read lands in the output register one edge before its beat is shown.
  assign re = ~reset &&
              ((DIRECT_BURST && accept && !mem.mem_req_rw) ||
               ((state == RLAT) && (lat_cnt == LAT_LAST)) ||
               ((state == RBURST) && (beat_cnt != BEAT_LAST)));
  assign rd_base = (state == IDLE) ? idx_in : base;
  assign rd_off  = (state == RBURST) ? beat_cnt + LB'(1) : '0;
  assign raddr   = {rd_base[DEPTH_BITS-1:LB], rd_base[LB-1:0] + rd_off};

  mem_responder_store #(
    .DATA_BITS  (DATA_BITS),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_store (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (mem.mem_req_data_bits),
    .wmask (mem.mem_req_data_mask),
    .re    (re),
    .raddr (raddr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      base       <= '0;
      beat_cnt   <= '0;
      lat_cnt    <= '0;
      resp_valid <= 1'b0;
      data_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem.mem_req_valid) begin
            base <= idx_in;
            if (mem.mem_req_rw) begin
              if (!mem.mem_req_data_valid) state <= WDATA;
            end else begin
              beat_cnt <= '0;
              if (DIRECT_BURST) begin
                state      <= RBURST;
                resp_valid <= 1'b1;
                data_seen  <= 1'b1;
              end else begin
                state   <= RLAT;
                lat_cnt <= LW'(1);
              end
            end
          end
        end
        WDATA: begin
          if (mem.mem_req_data_valid) state <= IDLE;
        end
        RLAT: begin
          if (lat_cnt == LAT_LAST) begin
            state      <= RBURST;
            lat_cnt    <= '0;
            resp_valid <= 1'b1;
            data_seen  <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        RBURST: begin
          if (beat_cnt == BEAT_LAST) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            resp_valid <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + LB'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.mem_req_ready      = (state == IDLE);
  assign mem.mem_req_data_ready = (state == IDLE) || (state == WDATA);
  assign mem.mem_resp_valid     = resp_valid;
  assign mem.mem_resp_data      = data_seen ? rd_data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency-1 and latency-3 instances share one stimulus bus.
module tb_mem_responder;

  logic         clk;
  logic         reset;
  logic         use3;
  logic         req_valid;
  logic [27:0]  req_addr;
  logic         req_rw;
  logic         dvalid;
  logic [127:0] dbits;
  logic [15:0]  dmask;

  int n_checks;
  int n_errors;

  mem_responder_if m1 ();
  mem_responder_if m3 ();

  mem_responder #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .mem(m1));
  mem_responder #(.READ_LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .mem(m3));

  assign m1.mem_req_valid      = req_valid & ~use3;
  assign m3.mem_req_valid      = req_valid & use3;
  assign m1.mem_req_data_valid = dvalid & ~use3;
  assign m3.mem_req_data_valid = dvalid & use3;
  assign m1.mem_req_addr       = req_addr;
  assign m3.mem_req_addr       = req_addr;
  assign m1.mem_req_rw         = req_rw;
  assign m3.mem_req_rw         = req_rw;
  assign m1.mem_req_data_bits  = dbits;
  assign m3.mem_req_data_bits  = dbits;
  assign m1.mem_req_data_mask  = dmask;
  assign m3.mem_req_data_mask  = dmask;

  logic         rdy, drdy, vld;
  logic [127:0] rdat;
  assign rdy  = use3 ? m3.mem_req_ready      : m1.mem_req_ready;
  assign drdy = use3 ? m3.mem_req_data_ready : m1.mem_req_data_ready;
  assign vld  = use3 ? m3.mem_resp_valid     : m1.mem_resp_valid;
  assign rdat = use3 ? m3.mem_resp_data      : m1.mem_resp_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; command and data presented together.
  task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = a;
    dvalid = 1'b1; dbits = d; dmask = m;
    @(negedge clk);
    req_valid = 1'b0; dvalid = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [27:0] a, input int lat, input int nchk,
                         input logic [127:0] e0, input logic [127:0] e1,
                         input logic [127:0] e2, input logic [127:0] e3);
    logic [127:0] exp_b [4];
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
    check({tag, "_acc_rdy"}, rdy, 1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check({tag, "_lat_vld"}, vld, 0);
      check({tag, "_lat_rdy"}, rdy, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      check({tag, "_beat_vld"}, vld, 1);
      check({tag, "_beat_rdy"}, rdy, 0);
      if (i < nchk) check({tag, "_beat_dat"}, rdat, exp_b[i]);
      @(negedge clk);
    end
    check({tag, "_end_vld"}, vld, 0);
    check({tag, "_end_rdy"}, rdy, 1);
    if (nchk == 4) check({tag, "_hold_dat"}, rdat, exp_b[3]);
  endtask

  localparam logic [127:0] D_INC  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] D_MSK  = 128'h0F0E0D0C0B0A090807060504030201AA;
  localparam logic [127:0] D_AA   = {16{8'hAA}};
  localparam logic [127:0] D_55   = {16{8'h55}};
  localparam logic [127:0] D_EE   = {16{8'hEE}};
  localparam logic [127:0] D_FF   = {16{8'hFF}};

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; use3 = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_rw = 1'b0;
    dvalid = 1'b0; dbits = '0; dmask = '0;

    #1;
    check("rst_vld1",  m1.mem_resp_valid, 0);
    check("rst_dat1",  m1.mem_resp_data, 0);
    check("rst_rdy1",  m1.mem_req_ready, 1);
    check("rst_drdy1", m1.mem_req_data_ready, 1);
    check("rst_vld3",  m3.mem_resp_valid, 0);
    check("rst_rdy3",  m3.mem_req_ready, 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Masked write: only byte 0 replaced.
    do_write(28'h10, D_INC, 16'hFFFF);
    do_write(28'h10, D_AA, 16'h0001);
    do_read("mask", 28'h10, 1, 1, D_MSK, '0, '0, '0);

    // Line write then burst read, read issued the cycle after the last write.
    do_write(28'h20, 128'd1, 16'hFFFF);
    do_write(28'h21, 128'd2, 16'hFFFF);
    do_write(28'h22, 128'd3, 16'hFFFF);
    do_write(28'h23, 128'd4, 16'hFFFF);
    do_read("line", 28'h20, 1, 4, 128'd1, 128'd2, 128'd3, 128'd4);
    do_read("wrap2", 28'h22, 1, 4, 128'd3, 128'd4, 128'd1, 128'd2);

    // All-zero mask is a no-op; stray data_valid in IDLE is not consumed.
    do_write(28'h21, D_FF, 16'h0000);
    req_addr = 28'h22; req_rw = 1'b1; dvalid = 1'b1; dbits = D_EE; dmask = 16'hFFFF;
    check("stray_drdy", drdy, 1);
    @(negedge clk);
    dvalid = 1'b0;
    do_read("nowrite", 28'h21, 1, 4, 128'd2, 128'd3, 128'd4, 128'd1);

    // Split write with a read request held during WDATA.
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 28'h30; dvalid = 1'b0;
    check("split_acc_rdy", rdy, 1);
    @(negedge clk);
    req_rw = 1'b0; req_addr = 28'h20;
    for (int c = 1; c <= 3; c++) begin
      check("split_rdy", rdy, 0);
      check("split_drdy", drdy, 1);
      check("split_vld", vld, 0);
      if (c == 3) begin
        dvalid = 1'b1; dbits = D_55; dmask = 16'hFFFF;
      end
      @(negedge clk);
    end
    dvalid = 1'b0;
    do_read("held", 28'h20, 1, 4, 128'd1, 128'd2, 128'd3, 128'd4);
    do_read("split", 28'h30, 1, 1, D_55, '0, '0, '0);

    // Latency-3 instance.
    use3 = 1'b1;
    do_write(28'h20, 128'd1, 16'hFFFF);
    do_write(28'h21, 128'd2, 16'hFFFF);
    do_write(28'h22, 128'd3, 16'hFFFF);
    do_write(28'h23, 128'd4, 16'hFFFF);
    do_read("lat3", 28'h20, 3, 4, 128'd1, 128'd2, 128'd3, 128'd4);
    do_read("lat3w", 28'h23, 3, 4, 128'd4, 128'd1, 128'd2, 128'd3);
    use3 = 1'b0;

    // Reset during beat 1 of a burst.
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 28'h20;
    @(negedge clk);
    req_valid = 1'b0;
    check("rb_beat0_vld", vld, 1);
    @(negedge clk);
    check("rb_beat1_vld", vld, 1);
    #1 reset = 1'b1;
    #1;
    check("rb_async_vld", vld, 0);
    check("rb_rst_rdy", rdy, 1);
    check("rb_rst_drdy", drdy, 1);
    @(negedge clk);
    reset = 1'b0;
    check("rb_rel_vld", vld, 0);
    check("rb_rel_rdy", rdy, 1);
    do_read("after_rst", 28'h20, 1, 4, 128'd1, 128'd2, 128'd3, 128'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
